shared_reg_arbiter: RTL and testbench

Arbitrates write access to one shared WIDTH-bit storage register between two requesters, using a round-robin policy and a req/gnt/done handshake. Each requester issues one of four register operations: load, clear, preset or invert. The register is built from the team's D flip-flop cells with their PRE/CLR pins tied inactive. All clearing and presetting is therefore synchronous and issued by this controller. The block sits between lab-level command sources (switch/button FSMs) and the register feeding the display datapath.

---
 rtl/shared_reg_arbiter_if.sv | 24 ++
 rtl/shared_reg_arbiter.sv | 128 ++++++++++++
 tb/tb_shared_reg_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/shared_reg_arbiter_if.sv
// rtl/shared_reg_arbiter_if.sv - request/grant bus between two command sources and the shared register
interface shared_reg_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req;
  logic [1:0]       op0;
  logic [1:0]       op1;
  logic [WIDTH-1:0] wdata0;
  logic [WIDTH-1:0] wdata1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;
  logic [WIDTH-1:0] Q;

  modport master (
    output req, op0, op1, wdata0, wdata1,
    input  gnt, done, busy, Q
  );

  modport slave (
    input  req, op0, op1, wdata0, wdata1,
    output gnt, done, busy, Q
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin write arbiter for one shared WIDTH-bit register
module shared_reg_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  shared_reg_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_APPLY   = 3'd2,
    S_DONE    = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;
  localparam logic [1:0] OP_INVERT = 2'b11;

  state_e           state_q, state_d;
  logic             winner_q, winner_d;
  logic             last_q, last_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] reg_q, reg_d;

  logic             pick;
  logic [WIDTH-1:0] op_result;
  logic [1:0]       winner_onehot;
  logic [1:0]       gnt_o;
  logic [1:0]       done_o;
  logic             busy_o;

  // On a tie the requester that was not served last wins.
  assign pick = (bus.req == 2'b10) || ((bus.req == 2'b11) && !last_q);

  assign winner_onehot = winner_q ? 2'b10 : 2'b01;

  always_comb begin
    op_result = reg_q;
    case (op_q)
      OP_LOAD:   op_result = data_q;
      OP_CLEAR:  op_result = '0;
      OP_PRESET: op_result = '1;
      OP_INVERT: op_result = ~reg_q;
      default:   op_result = reg_q;
    endcase
  end

  // The storage cells have no async pins, so reset clears everything here.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      winner_q <= 1'b0;
      last_q   <= 1'b1;
      op_q     <= OP_LOAD;
      data_q   <= '0;
      reg_q    <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      op_q     <= op_d;
      data_q   <= data_d;
      reg_q    <= reg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    op_d     = op_q;
    data_d   = data_q;
    reg_d    = reg_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req != 2'b00) begin
          winner_d = pick;
          op_d     = pick ? bus.op1 : bus.op0;
          data_d   = pick ? bus.wdata1 : bus.wdata0;
          state_d  = S_GRANT;
        end
      end
      S_GRANT: begin
        state_d = S_APPLY;
      end
      S_APPLY: begin
        reg_d   = op_result;
        state_d = S_DONE;
      end
      S_DONE: begin
        last_d  = winner_q;
        state_d = bus.req[winner_q] ? S_RELEASE : S_IDLE;
      end
      S_RELEASE: begin
        if (!bus.req[winner_q]) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    gnt_o  = 2'b00;
    done_o = 2'b00;
    busy_o = 1'b0;
    if (state_q != S_IDLE) begin
      gnt_o  = winner_onehot;
      busy_o = 1'b1;
    end
    if (state_q == S_DONE) begin
      done_o = winner_onehot;
    end
  end

  assign bus.gnt  = gnt_o;
  assign bus.done = done_o;
  assign bus.busy = busy_o;
  assign bus.Q    = reg_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - directed and random checks of shared_reg_arbiter against a transaction model
module tb_shared_reg_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Transaction-level model: register value and who was served last.
  logic [3:0] mq    = 4'h0;
  logic       mlast = 1'b1;

  shared_reg_arbiter_if #(.WIDTH(4)) bus ();

  shared_reg_arbiter #(.WIDTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] apply_op(input logic [1:0] op, input logic [3:0] d, input logic [3:0] q);
    case (op)
      2'b00:   return d;
      2'b01:   return 4'h0;
      2'b10:   return 4'hF;
      default: return ~q;
    endcase
  endfunction

  // One full transaction starting from IDLE; requests are sampled at the next edge.
  task automatic run_txn(input logic [1:0] reqs, input logic [1:0] o0, input logic [1:0] o1,
                         input logic [3:0] d0, input logic [3:0] d1, input int hold);
    logic       w;
    logic [1:0] eg;
    logic [3:0] eq;
    w  = (reqs == 2'b01) ? 1'b0 : (reqs == 2'b10) ? 1'b1 : ~mlast;
    eg = w ? 2'b10 : 2'b01;
    eq = apply_op(w ? o1 : o0, w ? d1 : d0, mq);
    bus.req = reqs; bus.op0 = o0; bus.op1 = o1; bus.wdata0 = d0; bus.wdata1 = d1;
    tick();
    chk("c1_gnt", bus.gnt, eg);
    chk("c1_busy", bus.busy, 1);
    chk("c1_done", bus.done, 0);
    chk("c1_q", bus.Q, mq);
    // Captured op/data must be used, not whatever the source drives now.
    bus.op0 = 2'($urandom); bus.op1 = 2'($urandom);
    bus.wdata0 = 4'($urandom); bus.wdata1 = 4'($urandom);
    tick();
    chk("c2_gnt", bus.gnt, eg);
    chk("c2_done", bus.done, 0);
    chk("c2_q", bus.Q, mq);
    tick();
    chk("c3_gnt", bus.gnt, eg);
    chk("c3_done", bus.done, eg);
    chk("c3_q", bus.Q, eq);
    mq = eq;
    mlast = w;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("rel_gnt", bus.gnt, eg);
      chk("rel_done", bus.done, 0);
      chk("rel_busy", bus.busy, 1);
    end
    bus.req = reqs & ~eg;
    tick();
    chk("end_gnt", bus.gnt, 0);
    chk("end_done", bus.done, 0);
    chk("end_busy", bus.busy, 0);
    chk("end_q", bus.Q, mq);
  endtask

  initial begin
    bus.req = 2'b11; bus.op0 = 2'b00; bus.op1 = 2'b00; bus.wdata0 = 4'h0; bus.wdata1 = 4'h0;
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_q", bus.Q, 0);
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_busy", bus.busy, 0);
    end
    RST = 1'b1;

    // Tie from reset: requester 0 first, then strict alternation.
    run_txn(2'b11, 2'b00, 2'b00, 4'b0011, 4'b1100, 0);
    chk("tie_first_q", bus.Q, 4'b0011);
    run_txn(2'b11, 2'b00, 2'b00, 4'b0011, 4'b1100, 0);
    chk("tie_second_q", bus.Q, 4'b1100);
    run_txn(2'b11, 2'b00, 2'b00, 4'b0011, 4'b1100, 0);
    chk("tie_third_q", bus.Q, 4'b0011);
    run_txn(2'b11, 2'b00, 2'b00, 4'b0011, 4'b1100, 0);
    chk("tie_fourth_q", bus.Q, 4'b1100);

    run_txn(2'b01, 2'b00, 2'b00, 4'b1010, 4'h0, 0);
    chk("load_q", bus.Q, 4'b1010);

    run_txn(2'b10, 2'b00, 2'b10, 4'h0, 4'h0, 0);
    chk("preset_q", bus.Q, 4'b1111);
    run_txn(2'b10, 2'b00, 2'b11, 4'h0, 4'h0, 0);
    chk("invert1_q", bus.Q, 4'b0000);
    run_txn(2'b10, 2'b00, 2'b00, 4'h0, 4'b0110, 0);
    chk("load6_q", bus.Q, 4'b0110);
    run_txn(2'b10, 2'b00, 2'b11, 4'h0, 4'h0, 0);
    chk("invert2_q", bus.Q, 4'b1001);
    run_txn(2'b10, 2'b00, 2'b01, 4'h0, 4'h0, 0);
    chk("clear_q", bus.Q, 4'b0000);

    // Reset asserted during APPLY kills the transaction.
    run_txn(2'b01, 2'b00, 2'b00, 4'b0101, 4'h0, 0);
    chk("pre_rst_q", bus.Q, 4'b0101);
    bus.req = 2'b01; bus.op0 = 2'b00; bus.wdata0 = 4'b1111;
    tick();
    chk("mid_grant_gnt", bus.gnt, 2'b01);
    tick();
    chk("mid_apply_gnt", bus.gnt, 2'b01);
    chk("mid_apply_q", bus.Q, 4'b0101);
    RST = 1'b0;
    tick();
    chk("mid_rst_q", bus.Q, 0);
    chk("mid_rst_gnt", bus.gnt, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_busy", bus.busy, 0);
    RST = 1'b1;
    bus.req = 2'b00;
    tick();
    chk("post_rst_done", bus.done, 0);
    chk("post_rst_q", bus.Q, 0);
    mq = 4'h0;
    mlast = 1'b1;

    // Requester 0 holds after done; requester 1 must wait for IDLE.
    run_txn(2'b11, 2'b00, 2'b00, 4'b0011, 4'b1100, 5);
    chk("held_q", bus.Q, 4'b0011);
    run_txn(2'b10, 2'b00, 2'b00, 4'h0, 4'b1100, 0);
    chk("after_held_q", bus.Q, 4'b1100);

    for (int n = 0; n < 30; n++) begin
      run_txn(2'($urandom_range(1, 3)), 2'($urandom), 2'($urandom),
              4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
